// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: decodes loads/stores, drives a req/ack data
// memory handshake, aligns store lanes and formats load data for MEM/WB.
module mem_stage_lsu #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] instruction_MEM_in,
   input  logic            valid_MEM_in,
   input  logic [size-1:0] ALU_out_MEM_in,
   input  logic [size-1:0] data2_MEM_in,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [size-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [size-1:0] dmem_wdata,
   input  logic [size-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic [size-1:0] DMEM_out_MEM,
   output logic            mem_stall,
   output logic            mem_exc
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_t;

   state_t          r_state;
   logic            r_req;
   logic            r_we;
   logic [size-1:0] r_addr;
   logic [3:0]      r_be;
   logic [size-1:0] r_wdata;
   logic [size-1:0] r_dout;
   logic [2:0]      r_f3;
   logic [1:0]      r_lo;

   logic [6:0]      w_opc;
   logic [2:0]      w_f3;
   logic [1:0]      w_lo;
   logic            w_is_ld;
   logic            w_is_st;
   logic            w_bad_f3;
   logic            w_misal;
   logic            w_idle;
   logic            w_go;
   logic [3:0]      w_be;
   logic [size-1:0] w_wdata;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [size-1:0] w_fmt;
   logic            w_unused;

   assign w_opc    = instruction_MEM_in[6:0];
   assign w_f3     = instruction_MEM_in[14:12];
   assign w_lo     = ALU_out_MEM_in[1:0];
   assign w_unused = ^{instruction_MEM_in[size-1:15],
                       instruction_MEM_in[11:7]};

   assign w_is_ld = valid_MEM_in && (w_opc == OP_LOAD);
   assign w_is_st = valid_MEM_in && (w_opc == OP_STORE);
   assign w_idle  = (r_state == S_IDLE);

   always_comb begin
      w_bad_f3 = 1'b0;
      w_misal  = 1'b0;
      if (w_is_ld) begin
         case (w_f3)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_bad_f3 = 1'b0;
            default:                      w_bad_f3 = 1'b1;
         endcase
      end
      if (w_is_st) begin
         w_bad_f3 = (w_f3 > 3'd2);
      end
      // Access width comes from funct3[1:0]: 01 half, 10 word
      if (w_is_ld || w_is_st) begin
         case (w_f3[1:0])
            2'b01:   w_misal = w_lo[0];
            2'b10:   w_misal = (w_lo != 2'b00);
            default: w_misal = 1'b0;
         endcase
      end
   end

   assign w_go = w_idle && (w_is_ld || w_is_st) && !w_bad_f3 && !w_misal;

   assign mem_exc   = reset && w_idle && (w_is_ld || w_is_st)
                      && (w_bad_f3 || w_misal);
   assign mem_stall = reset && (w_go || (r_state == S_REQ));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = data2_MEM_in;
      if (w_is_st) begin
         case (w_f3[1:0])
            2'b00: begin
               w_be    = 4'b0001 << w_lo;
               w_wdata = {4{data2_MEM_in[7:0]}};
            end
            2'b01: begin
               w_be    = 4'b0011 << {w_lo[1], 1'b0};
               w_wdata = {2{data2_MEM_in[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = data2_MEM_in;
            end
         endcase
      end
   end

   always_comb begin
      case (r_lo)
         2'd0:    w_byte = dmem_rdata[7:0];
         2'd1:    w_byte = dmem_rdata[15:8];
         2'd2:    w_byte = dmem_rdata[23:16];
         default: w_byte = dmem_rdata[31:24];
      endcase
      w_half = r_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (r_f3)
         3'd0:    w_fmt = {{24{w_byte[7]}}, w_byte};
         3'd1:    w_fmt = {{16{w_half[15]}}, w_half};
         3'd4:    w_fmt = {24'd0, w_byte};
         3'd5:    w_fmt = {16'd0, w_half};
         default: w_fmt = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= 4'b0000;
         r_wdata <= '0;
         r_dout  <= '0;
         r_f3    <= 3'd0;
         r_lo    <= 2'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
                  r_we    <= w_is_st;
                  r_addr  <= {ALU_out_MEM_in[size-1:2], 2'b00};
                  r_be    <= w_be;
                  r_wdata <= w_wdata;
                  r_f3    <= w_f3;
                  r_lo    <= w_lo;
               end
            end
            S_REQ: begin
               if (dmem_ack) begin
                  r_state <= S_DONE;
                  r_req   <= 1'b0;
                  if (!r_we) r_dout <= w_fmt;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dmem_req     = r_req;
   assign dmem_we      = r_we;
   assign dmem_addr    = r_addr;
   assign dmem_be      = r_be;
   assign dmem_wdata   = r_wdata;
   assign DMEM_out_MEM = r_dout;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a load-result scoreboard.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        valid;
   logic [31:0] alu;
   logic [31:0] d2;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic [31:0] dout;
   logic        mem_stall;
   logic        mem_exc;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_ld;

   always #5 clk = ~clk;

   mem_stage_lsu #(.size(32)) dut (
      .clk                (clk),
      .reset              (reset),
      .instruction_MEM_in (instr),
      .valid_MEM_in       (valid),
      .ALU_out_MEM_in     (alu),
      .data2_MEM_in       (d2),
      .dmem_req           (dmem_req),
      .dmem_we            (dmem_we),
      .dmem_addr          (dmem_addr),
      .dmem_be            (dmem_be),
      .dmem_wdata         (dmem_wdata),
      .dmem_rdata         (dmem_rdata),
      .dmem_ack           (dmem_ack),
      .DMEM_out_MEM       (dout),
      .mem_stall          (mem_stall),
      .mem_exc            (mem_exc)
   );

   function automatic logic [31:0] ld_i(input logic [2:0] f3);
      return {17'd0, f3, 5'd1, 7'h03};
   endfunction

   function automatic logic [31:0] st_i(input logic [2:0] f3);
      return {17'd0, f3, 5'd0, 7'h23};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic access(input string tag, input logic [31:0] ins,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int lat,
                         input bit ld, input logic [31:0] exp,
                         output int nreq, output int nstall,
                         output logic [31:0] o_addr,
                         output logic [31:0] o_wd,
                         output logic [3:0] o_be, output logic o_we);
      bit done;
      bit seen;
      done   = 1'b0;
      seen   = 1'b0;
      nreq   = 0;
      nstall = 0;
      o_addr = '0;
      o_wd   = '0;
      o_be   = '0;
      o_we   = 1'b0;
      instr  = ins;
      valid  = 1'b1;
      alu    = addr;
      d2     = wd;
      dmem_rdata = rd;
      dmem_ack   = 1'b0;
      if (ld) sb_q.push_back(exp);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (mem_stall) nstall++;
         if (dmem_req) begin
            if (nreq == 0) begin
               o_addr = dmem_addr;
               o_wd   = dmem_wdata;
               o_be   = dmem_be;
               o_we   = dmem_we;
            end
            nreq++;
            seen = 1'b1;
            if (nreq == lat) dmem_ack = 1'b1;
         end else if (seen && !mem_stall) begin
            done = 1'b1;
            if (ld) begin
               chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
               if (sb_q.size() > 0) begin
                  last_ld = sb_q.pop_front();
                  chk({tag, "_data"}, dout, last_ld);
               end
            end else begin
               chk({tag, "_dout_kept"}, dout, last_ld);
            end
         end
         @(posedge clk);
         #1;
         dmem_ack = 1'b0;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      valid = 1'b0;
      instr = 32'h0000_0013;
   endtask

   initial begin
      int          nr;
      int          ns;
      logic [31:0] oa;
      logic [31:0] ow;
      logic [3:0]  ob;
      logic        owe;

      reset      = 1'b0;
      instr      = 32'h0000_0013;
      valid      = 1'b0;
      alu        = '0;
      d2         = '0;
      dmem_rdata = '0;
      dmem_ack   = 1'b0;
      last_ld    = '0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_req",   32'(dmem_req),  32'd0);
      chk("rst_we",    32'(dmem_we),   32'd0);
      chk("rst_addr",  dmem_addr,      32'd0);
      chk("rst_wdata", dmem_wdata,     32'd0);
      chk("rst_be",    32'(dmem_be),   32'd0);
      chk("rst_dout",  dout,           32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_exc",   32'(mem_exc),   32'd0);
      tick();
      reset = 1'b1;
      tick();

      access("lw_wait", ld_i(3'd2), 32'h100, 32'h0, 32'hDEADBEEF, 3,
             1'b1, 32'hDEADBEEF, nr, ns, oa, ow, ob, owe);
      chk("lw_wait_nreq",   32'(nr),  32'd3);
      chk("lw_wait_nstall", 32'(ns),  32'd4);
      chk("lw_wait_be",     32'(ob),  32'hF);
      chk("lw_wait_we",     32'(owe), 32'd0);
      chk("lw_wait_addr",   oa,       32'h100);

      access("lb", ld_i(3'd0), 32'h103, 32'h0, 32'h80112233, 1,
             1'b1, 32'hFFFFFF80, nr, ns, oa, ow, ob, owe);
      chk("lb_nstall", 32'(ns), 32'd2);
      chk("lb_addr",   oa,      32'h100);
      access("lbu", ld_i(3'd4), 32'h103, 32'h0, 32'h80112233, 1,
             1'b1, 32'h00000080, nr, ns, oa, ow, ob, owe);
      access("lh", ld_i(3'd1), 32'h102, 32'h0, 32'h80112233, 1,
             1'b1, 32'hFFFF8011, nr, ns, oa, ow, ob, owe);
      access("lhu", ld_i(3'd5), 32'h100, 32'h0, 32'h80112233, 1,
             1'b1, 32'h00002233, nr, ns, oa, ow, ob, owe);
      chk("lhu_nreq", 32'(nr), 32'd1);

      access("sb", st_i(3'd0), 32'h101, 32'h123456A5, 32'h0, 1,
             1'b0, 32'h0, nr, ns, oa, ow, ob, owe);
      chk("sb_we",    32'(owe), 32'd1);
      chk("sb_be",    32'(ob),  32'b0010);
      chk("sb_wdata", ow,       32'hA5A5A5A5);
      chk("sb_addr",  oa,       32'h100);

      instr = ld_i(3'd2);
      alu   = 32'h102;
      valid = 1'b1;
      @(negedge clk);
      chk("lw_mis_exc",   32'(mem_exc),   32'd1);
      chk("lw_mis_stall", 32'(mem_stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("lw_mis_noreq", 32'(dmem_req), 32'd0);
      end
      tick();
      instr = st_i(3'd1);
      alu   = 32'h0FF;
      d2    = 32'h5555AAAA;
      @(negedge clk);
      chk("sh_mis_exc",   32'(mem_exc),   32'd1);
      chk("sh_mis_stall", 32'(mem_stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("sh_mis_noreq", 32'(dmem_req), 32'd0);
      end
      chk("sh_mis_dout", dout, last_ld);
      tick();
      valid = 1'b0;
      tick();

      instr = ld_i(3'd2);
      alu   = 32'h300;
      valid = 1'b1;
      tick();
      @(negedge clk);
      chk("rstmid_req_on", 32'(dmem_req), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rstmid_req",   32'(dmem_req),  32'd0);
      chk("rstmid_dout",  dout,           32'd0);
      chk("rstmid_stall", 32'(mem_stall), 32'd0);
      last_ld = '0;
      valid   = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_req",   32'(dmem_req),  32'd0);
         chk("post_rst_stall", 32'(mem_stall), 32'd0);
         tick();
      end

      instr = 32'h00208033;
      alu   = 32'h204;
      valid = 1'b1;
      @(negedge clk);
      chk("add_stall", 32'(mem_stall), 32'd0);
      chk("add_exc",   32'(mem_exc),   32'd0);
      tick();
      access("seq_lw", ld_i(3'd2), 32'h200, 32'h0, 32'h0BADF00D, 1,
             1'b1, 32'h0BADF00D, nr, ns, oa, ow, ob, owe);
      chk("seq_lw_nstall", 32'(ns), 32'd2);
      access("seq_sw", st_i(3'd2), 32'h204, 32'hCAFEBABE, 32'h0, 1,
             1'b0, 32'h0, nr, ns, oa, ow, ob, owe);
      chk("seq_sw_nstall", 32'(ns), 32'd2);
      chk("seq_sw_be",     32'(ob), 32'hF);
      chk("seq_sw_wdata",  ow,      32'hCAFEBABE);
      chk("seq_sw_addr",   oa,      32'h204);
      chk("sb_drained",    32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the RV32I pipeline. It sits between the EX/MEM stage register and the MEM/WB stage register. It decodes load/store instructions and drives a variable-latency data-memory request/acknowledge handshake. It also performs byte-lane alignment, store-data replication and load sign/zero extension, and stalls the pipeline until the access completes. Its formatted load result feeds the `DMEM_out_MEM` input of the MEM/WB register.

## Interface
- `size`, 32, datapath and address width.

- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `instruction_MEM_in`  in  size  MEM-stage instruction; opcode `[6:0]`, funct3 `[14:12]`.
- `valid_MEM_in`  in  1  instruction in MEM is valid (not a bubble).
- `ALU_out_MEM_in`  in  size  effective byte address.
- `data2_MEM_in`  in  size  store data (rs2).
- `dmem_req`  out  1  memory request, held until acknowledged.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  size  word-aligned address, `{addr[31:2], 2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  size  lane-replicated store data.
- `dmem_rdata`  in  size  read word, valid when `dmem_ack`=1.
- `dmem_ack`  in  1  access complete.
- `DMEM_out_MEM`  out  size  formatted load data to MEM/WB.
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB.
- `mem_exc`  out  1  misaligned or illegal-funct3 access.

## Operation
- Memory op: `valid_MEM_in`=1 and opcode is LOAD (`0000011`) or STORE (`0100011`).
- FSM states: IDLE, REQ, DONE.
  - IDLE, legal memory op present: latch `dmem_addr`, `dmem_we`, `dmem_be`, `dmem_wdata`, funct3 and `addr[1:0]`; next state REQ.
  - IDLE, no memory op or `mem_exc`: stay in IDLE.
  - REQ: `dmem_req`=1. Request outputs stay stable until `dmem_ack`. On ack, next state DONE; for loads, register the formatted data into `DMEM_out_MEM`.
  - DONE: `dmem_req`=0; unconditionally go to IDLE next cycle.
- `mem_stall` (combinational) is 1 when (IDLE and legal memory op) or in REQ. It is 0 in DONE.
- `mem_exc` (combinational, IDLE only) is 1 for any of:
  - LH/LHU/SH with `addr[0]`=1;
  - LW/SW with `addr[1:0]`≠0;
  - load funct3 ∈ {3, 6, 7};
  - store funct3 > 2.
- On `mem_exc`: no request, no stall, `DMEM_out_MEM` unchanged.
- Byte enables:
  - Loads: 4'b1111.
  - SB: 4'b0001 << `addr[1:0]`.
  - SH: 4'b0011 << {`addr[1]`, 0}.
  - SW: 4'b1111.
- Store data:
  - SB: `{4{rs2[7:0]}}`.
  - SH: `{2{rs2[15:0]}}`.
  - SW: rs2 unchanged.
- Load formatting (lane selected by the latched `addr[1:0]`):
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: word passed through.
- `DMEM_out_MEM` updates only on a load acknowledge. Stores and non-memory instructions leave it unchanged.
- `dmem_ack` outside REQ is ignored.

## Timing
- Reset values (asynchronous, take effect immediately, including mid-transaction):
  - state IDLE;
  - `dmem_req`, `dmem_we` = 0;
  - `dmem_addr`, `dmem_wdata`, `DMEM_out_MEM` = 0;
  - `dmem_be` = 0;
  - `mem_stall`, `mem_exc` = 0.
- After reset is released, no request is issued until a new memory op is seen in IDLE.
- Memory op first seen in cycle 0:
  - `dmem_req` rises in cycle 1;
  - ack in cycle N (N ≥ 1) gives DONE in cycle N+1;
  - `mem_stall` is high for cycles 0..N (N+1 cycles);
  - MEM/WB captures `DMEM_out_MEM` at the end of cycle N+1.
- Zero-wait memory (ack in cycle 1): 2 stall cycles per access.
- Back-to-back memory ops: the second op enters IDLE in cycle N+2 and issues normally. There are no dead cycles beyond DONE.
- Non-memory instructions pass through with 0 added latency.

## Test plan
- LW at 0x100, ack 3 cycles after `dmem_req` rises with rdata 0xDEADBEEF.
  - Required: `dmem_req` high for 3 cycles, `mem_stall` high for 4 cycles, `DMEM_out_MEM` = 0xDEADBEEF in DONE, `dmem_be` = 4'b1111, `dmem_we` = 0.
- rdata 0x80112233 with immediate ack:
  - LB at 0x103 → 0xFFFFFF80;
  - LBU at 0x103 → 0x00000080;
  - LH at 0x102 → 0xFFFF8011;
  - LHU at 0x100 → 0x00002233.
- SB at 0x101 with rs2 = 0x123456A5.
  - Required: `dmem_we` = 1, `dmem_be` = 4'b0010, `dmem_wdata` = 0xA5A5A5A5, `dmem_addr` = 0x100, `DMEM_out_MEM` unchanged.
- LW at 0x102, and separately SH at 0x0FF.
  - Required: `mem_exc` = 1 for that cycle, `dmem_req` never asserts, `mem_stall` = 0.
- Reset asserted while in REQ with no ack pending.
  - Required: `dmem_req` and `DMEM_out_MEM` go to 0 immediately. After release, with `valid_MEM_in` = 0, there is no request and no stall for 5 cycles.
- Sequence ADD → LW 0x200 → SW 0x204 with immediate ack.
  - Required: ADD has no stall; each memory op stalls exactly 2 cycles; SW `dmem_be` = 4'b1111; the LW result is visible in its DONE cycle.
